detect_sequence_prog: RTL and testbench

//  Runtime-programmable serial sequence detector. Successor to the fixed 8-bit detector.

---
 rtl/detect_sequence_prog.sv | 202 ++++++++++++++++++++
 tb/tb_detect_sequence_prog.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/detect_sequence_prog.sv
`default_nettype none
// ============================================================================
//  Module      : detect_sequence_prog
//  Description : Runtime-programmable serial sequence detector. Pattern,
//                length and overlap mode are loaded at run time; stream bits
//                are qualified by a valid strobe; the registered match pulse
//                feeds a saturating match counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module detect_sequence_prog #(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_load_i,
    input  logic [W-1:0]               cfg_pattern_i,
    input  logic [$clog2(W+1)-1:0]     cfg_len_i,
    input  logic                       cfg_overlap_i,
    input  logic                       in_vld_i,
    input  logic                       in_i,
    output logic                       match_o,
    output logic [CNT_W-1:0]           match_cnt_o,
    output logic                       armed_o
);

    localparam int LW = $clog2(W+1);

    // Detector state, decoded from the length and fill registers
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_HUNT = 2'd2;

    logic [W-1:0]     pattern_q, pattern_d;
    logic [LW-1:0]    len_q,     len_d;
    logic             overlap_q, overlap_d;
    logic [W-1:0]     history_q, history_d;
    logic [LW-1:0]    fill_q,    fill_d;
    logic             match_q,   match_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;

    logic [LW-1:0]    len_clamped;
    logic             accept;
    logic [W-1:0]     hist_nxt;
    logic [LW-1:0]    fill_nxt;
    logic [W-1:0]     mask;
    logic             hit;
    logic [1:0]       state;

    // Datapath: next history/fill and the match decision on next-state values
    always_comb begin
        len_clamped = (cfg_len_i > LW'(W)) ? LW'(W) : cfg_len_i;
        accept      = in_vld_i && !cfg_load_i && (len_q != '0);
        hist_nxt    = accept ? {history_q[W-2:0], in_i} : history_q;
        fill_nxt    = fill_q;
        if (accept && (fill_q != LW'(W))) begin
            fill_nxt = fill_q + 1'b1;
        end
        // Full-width length would overflow the shift, so it selects all ones
        mask = (len_q >= LW'(W)) ? '1 : ((W'(1) << len_q) - W'(1));
        hit  = accept && (fill_nxt >= len_q) && (((hist_nxt ^ pattern_q) & mask) == '0);
    end

    // Next-state selection; configuration load takes priority over stream bits
    always_comb begin
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        history_d = history_q;
        fill_d    = fill_q;
        match_d   = 1'b0;
        cnt_d     = cnt_q;
        if (cfg_load_i) begin
            pattern_d = cfg_pattern_i;
            len_d     = len_clamped;
            overlap_d = cfg_overlap_i;
            history_d = '0;
            fill_d    = '0;
            cnt_d     = '0;
        end else if (accept) begin
            history_d = hist_nxt;
            fill_d    = fill_nxt;
            if (hit) begin
                match_d = 1'b1;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Non-overlapping mode demands a full set of fresh bits
                if (!overlap_q) begin
                    fill_d = '0;
                end
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            history_q <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            history_q <= history_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            cnt_q     <= cnt_d;
        end
    end

    // Decode the operating state from length and fill level
    always_comb begin
        if (len_q == '0) begin
            state = ST_IDLE;
        end else if (fill_q >= len_q) begin
            state = ST_HUNT;
        end else begin
            state = ST_FILL;
        end
    end

    assign match_o     = match_q;
    assign match_cnt_o = cnt_q;
    assign armed_o     = (state == ST_HUNT);

`ifndef SYNTHESIS
    // Reference automaton: ref_k_q counts how many leading pattern bits the
    // recent stream currently matches (prefix-function style), built
    // independently of the history/mask comparison above.
    logic [LW-1:0] ref_k_q;
    logic [LW-1:0] ref_nk;
    logic          ref_hit;

    function automatic logic [LW-1:0] ref_next(input logic [LW-1:0] k, input logic b,
                                               input logic [W-1:0] pat, input logic [LW-1:0] len);
        logic [LW-1:0] best;
        logic [W-1:0]  tmp;
        logic          ok;
        logic          sb;
        logic          pb;
        int            kk;
        int            ll;
        int            p;
        kk   = int'(k);
        ll   = int'(len);
        best = '0;
        for (int j = 1; j <= W; j++) begin
            if (j <= kk + 1 && j <= ll) begin
                ok = 1'b1;
                for (int i = 0; i < W; i++) begin
                    if (i < j) begin
                        p = kk + 1 - j + i;
                        if (p == kk) begin
                            sb = b;
                        end else begin
                            tmp = pat >> (ll - 1 - p);
                            sb  = tmp[0];
                        end
                        tmp = pat >> (ll - 1 - i);
                        pb  = tmp[0];
                        if (sb != pb) ok = 1'b0;
                    end
                end
                if (ok) best = LW'(j);
            end
        end
        return best;
    endfunction

    // Reference prediction for the bit presented this cycle
    always_comb begin
        ref_nk  = ref_next(ref_k_q, in_i, pattern_q, len_q);
        ref_hit = accept && (ref_nk == len_q);
    end

    // Reference state update mirrors load/clear/overlap semantics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_k_q <= '0;
        end else if (cfg_load_i) begin
            ref_k_q <= '0;
        end else if (accept) begin
            ref_k_q <= (ref_hit && !overlap_q) ? '0 : ref_nk;
        end
    end

    // Flag any disagreement between the reference and the datapath compare
    always @(posedge clk) begin
        if (rst_n && accept) begin
            assert (ref_hit == hit);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_detect_sequence_prog.sv
`default_nettype none
// ============================================================================
//  Module      : tb_detect_sequence_prog
//  Description : Self-checking bench for detect_sequence_prog: a table of
//                directed vectors plus hand-written gap, saturation and
//                asynchronous-reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_detect_sequence_prog;

    logic       clk;
    logic       rst_n;
    logic       cfg_load;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       in_vld;
    logic       in_bit;
    logic       match;
    logic [7:0] match_cnt;
    logic       armed;
    logic       match4;
    logic [3:0] match_cnt4;
    logic       armed4;

    int checks   = 0;
    int failures = 0;

    detect_sequence_prog #(.W(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_load_i(cfg_load), .cfg_pattern_i(cfg_pattern),
        .cfg_len_i(cfg_len), .cfg_overlap_i(cfg_overlap), .in_vld_i(in_vld), .in_i(in_bit),
        .match_o(match), .match_cnt_o(match_cnt), .armed_o(armed)
    );

    detect_sequence_prog #(.W(8), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .cfg_load_i(cfg_load), .cfg_pattern_i(cfg_pattern),
        .cfg_len_i(cfg_len), .cfg_overlap_i(cfg_overlap), .in_vld_i(in_vld), .in_i(in_bit),
        .match_o(match4), .match_cnt_o(match_cnt4), .armed_o(armed4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ld;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ovl;
        logic       vld;
        logic       b;
        logic       exp_m;
        int         exp_cnt;
        logic       exp_a;
    } vec_t;

    vec_t vec[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Present one cycle of inputs, then return 1ns after the capturing edge
    task automatic cyc(input logic ld, input logic [7:0] p, input logic [3:0] l,
                       input logic o, input logic v, input logic b);
        cfg_load    = ld;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        in_vld      = v;
        in_bit      = b;
        @(posedge clk);
        #1;
    endtask

    task automatic ld(input logic [7:0] p, input logic [3:0] l, input logic o,
                      input logic m, input int c, input logic a);
        vec.push_back('{1'b1, p, l, o, 1'b0, 1'b0, m, c, a});
    endtask

    task automatic bt(input logic v, input logic b, input logic m, input int c, input logic a);
        vec.push_back('{1'b0, 8'h00, 4'd0, 1'b0, v, b, m, c, a});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] p1;
        p1 = 8'b10011010;

        // Scenario 1: full 8-bit pattern, overlapping
        ld(p1, 4'd8, 1'b1, 0, 0, 0);
        bt(1,1,0,0,0); bt(1,0,0,0,0); bt(1,0,0,0,0); bt(1,1,0,0,0);
        bt(1,1,0,0,0); bt(1,0,0,0,0); bt(1,1,0,0,0); bt(1,0,1,1,1);
        // Scenario 2, overlapping: 1,0,1,0,1
        ld(8'b101, 4'd3, 1'b1, 0, 0, 0);
        bt(1,1,0,0,0); bt(1,0,0,0,0); bt(1,1,1,1,1); bt(1,0,0,1,1); bt(1,1,1,2,1);
        bt(0,0,0,2,1);
        // Scenario 2, non-overlapping
        ld(8'b101, 4'd3, 1'b0, 0, 0, 0);
        bt(1,1,0,0,0); bt(1,0,0,0,0); bt(1,1,1,1,0); bt(1,0,0,1,0); bt(1,1,0,1,0);
        // Length 0: stream ignored
        ld(8'hFF, 4'd0, 1'b1, 0, 0, 0);
        bt(1,1,0,0,0); bt(1,1,0,0,0);
        // Length above W clamps to W
        ld(p1, 4'd15, 1'b1, 0, 0, 0);
        bt(1,1,0,0,0); bt(1,0,0,0,0); bt(1,0,0,0,0); bt(1,1,0,0,0);
        bt(1,1,0,0,0); bt(1,0,0,0,0); bt(1,1,0,0,0); bt(1,0,1,1,1);
        // Scenario 5: reload with a valid bit after 5 of 8 bits
        ld(p1, 4'd8, 1'b1, 0, 0, 0);
        bt(1,1,0,0,0); bt(1,0,0,0,0); bt(1,0,0,0,0); bt(1,1,0,0,0); bt(1,1,0,0,0);
        vec.push_back('{1'b1, p1, 4'd8, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0});
        bt(1,0,0,0,0); bt(1,0,0,0,0); bt(1,1,0,0,0); bt(1,1,0,0,0);
        bt(1,0,0,0,0); bt(1,1,0,0,0); bt(1,0,0,0,0);
        bt(1,1,0,0,1); bt(1,0,0,0,1); bt(1,0,0,0,1); bt(1,1,0,0,1);
        bt(1,1,0,0,1); bt(1,0,0,0,1); bt(1,1,0,0,1); bt(1,0,1,1,1);

        // Reset state, checked while reset is held and before any edge
        rst_n = 1'b0;
        cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        in_vld = 1'b0; in_bit = 1'b0;
        #2;
        chk("reset match", int'(match), 0);
        chk("reset cnt", int'(match_cnt), 0);
        chk("reset armed", int'(armed), 0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vec[i]) begin
            cyc(vec[i].ld, vec[i].pat, vec[i].len, vec[i].ovl, vec[i].vld, vec[i].b);
            chk($sformatf("vec%0d match", i), int'(match), int'(vec[i].exp_m));
            chk($sformatf("vec%0d cnt", i), int'(match_cnt), vec[i].exp_cnt);
            chk($sformatf("vec%0d armed", i), int'(armed), int'(vec[i].exp_a));
        end

        // Scenario 3: three idle cycles between every bit
        cyc(1'b1, p1, 4'd8, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, p1[7-i]);
            chk($sformatf("gap bit%0d match", i), int'(match), (i == 7) ? 1 : 0);
            chk($sformatf("gap bit%0d armed", i), int'(armed), (i == 7) ? 1 : 0);
            for (int g = 0; g < 3; g++) begin
                cyc(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1);
                chk($sformatf("gap bit%0d idle%0d match", i, g), int'(match), 0);
            end
        end
        chk("gap cnt", int'(match_cnt), 1);

        // Scenario 4: length-1 pattern, counter saturation on the 4-bit copy
        cyc(1'b1, 8'h01, 4'd1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1);
            chk($sformatf("sat%0d match4", i), int'(match4), 1);
            chk($sformatf("sat%0d cnt4", i), int'(match_cnt4), (i + 1 > 15) ? 15 : i + 1);
            chk($sformatf("sat%0d cnt8", i), int'(match_cnt), i + 1);
        end
        cyc(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0);
        chk("sat zero-bit match", int'(match), 0);
        chk("sat hold cnt4", int'(match_cnt4), 15);

        // Scenario 6: asynchronous reset between edges, mid-sequence
        cyc(1'b1, 8'h01, 4'd1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1);
        chk("pre-rst match", int'(match), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async rst match", int'(match), 0);
        chk("async rst cnt", int'(match_cnt), 0);
        chk("async rst armed", int'(armed), 0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1);
            chk($sformatf("post-rst%0d match", i), int'(match), 0);
            chk($sformatf("post-rst%0d armed", i), int'(armed), 0);
        end
        chk("post-rst cnt", int'(match_cnt), 0);
        cyc(1'b1, 8'h01, 4'd1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1);
        chk("reload match", int'(match), 1);
        chk("reload cnt", int'(match_cnt), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
